// File: rtl/m_timer_display_if.sv
// Kitchen-timer display bus: BCD time and control in, display drive out.
// Ports: min, sec, mode, time_end, ack_btn, blank_en -> seg, dig, buzzer.
interface m_timer_display_if;

    logic [7:0] min;
    logic [7:0] sec;
    logic       mode;
    logic       time_end;
    logic       ack_btn;
    logic       blank_en;
    logic [7:0] seg;
    logic [3:0] dig;
    logic       buzzer;

    modport master (
        output min,
        output sec,
        output mode,
        output time_end,
        output ack_btn,
        output blank_en,
        input  seg,
        input  dig,
        input  buzzer
    );

    modport slave (
        input  min,
        input  sec,
        input  mode,
        input  time_end,
        input  ack_btn,
        input  blank_en,
        output seg,
        output dig,
        output buzzer
    );

endinterface

// File: rtl/m_timer_display.sv
// Display/alarm back end: 4-digit muxed 7-seg with blinking colon,
// flashing display and gated buzzer tone on timer expiry.
// Ports: clk, rst_n (sync, active-low), bus (slave): min/sec/mode/
// time_end/ack_btn/blank_en in, seg {dp,g..a}/dig/buzzer out.
module m_timer_display #(
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_DIV      = 12500000,
    parameter int TONE_DIV       = 12500,
    parameter int ALARM_BEATS    = 20,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    m_timer_display_if.slave    bus
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam int AW = $clog2(ALARM_BEATS + 1);

    localparam logic [SW-1:0] SCAN_TC  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);
    localparam logic [TW-1:0] TONE_TC  = TW'(TONE_DIV - 1);
    localparam logic [AW-1:0] BEAT_MAX = AW'(ALARM_BEATS);

    // XOR masks: internal active-high value ^ mask = pin level.
    localparam logic [7:0] SEG_OFF =
        (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [3:0] DIG_OFF =
        (DIG_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    typedef enum logic [1:0] {
        IDLE,
        ALARM,
        SILENCED
    } state_t;

    state_t state;
    state_t state_nx;

    logic [1:0] mode_sy;
    logic [2:0] te_sy;
    logic [2:0] ack_sy;
    logic [1:0] warm;

    logic mode_s;
    logic te_s;
    logic te_rise;
    logic ack_rise;
    logic warm_done;

    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [7:0]    min_h;
    logic [7:0]    sec_h;

    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_cnt_nx;
    logic          phase;
    logic          phase_nx;
    logic          enter_alarm;

    logic [AW-1:0] beat;
    logic [TW-1:0] tone_cnt;

    logic [3:0] digit;
    logic [7:0] seg_int;
    logic [3:0] dig_int;

    logic [7:0] seg_q;
    logic [3:0] dig_q;
    logic       buzzer_q;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Synchronisers. After reset the edge detectors stay masked until
    // the third stage holds a real sample, so an input that was already
    // high during reset is not mistaken for a fresh rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_sy <= '0;
            te_sy   <= '0;
            ack_sy  <= '0;
            warm    <= '0;
        end else begin
            mode_sy <= {mode_sy[0], bus.mode};
            te_sy   <= {te_sy[1:0], bus.time_end};
            ack_sy  <= {ack_sy[1:0], bus.ack_btn};
            if (!warm_done) begin
                warm <= warm + 2'd1;
            end
        end
    end

    assign warm_done = (warm == 2'd3);
    assign mode_s    = mode_sy[1];
    assign te_s      = te_sy[1];
    assign te_rise   = warm_done && te_sy[1] && !te_sy[2];
    assign ack_rise  = warm_done && ack_sy[1] && !ack_sy[2];

    // Digit scan and time sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
            min_h    <= '0;
            sec_h    <= '0;
        end else if (scan_cnt == SCAN_TC) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
            min_h    <= bus.min;
            sec_h    <= bus.sec;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // State machine
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // An ack edge coinciding with entry is simply not looked at in IDLE.
    always_comb begin
        state_nx = state;
        unique case (1'b1)
            state == IDLE: begin
                if (te_rise && mode_s) begin
                    state_nx = ALARM;
                end
            end
            state == ALARM: begin
                if (!te_s || !mode_s) begin
                    state_nx = IDLE;
                end else if (ack_rise || beat == BEAT_MAX) begin
                    state_nx = SILENCED;
                end
            end
            state == SILENCED: begin
                if (!te_s || !mode_s) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign enter_alarm = (state == IDLE) && (state_nx == ALARM);

    // Blink: free-running, restarted in the lit half on alarm entry.
    always_comb begin
        blink_cnt_nx = blink_cnt + BW'(1);
        phase_nx     = phase;
        if (enter_alarm) begin
            blink_cnt_nx = '0;
            phase_nx     = 1'b1;
        end else if (blink_cnt == BLINK_TC) begin
            blink_cnt_nx = '0;
            phase_nx     = ~phase;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else begin
            blink_cnt <= blink_cnt_nx;
            phase     <= phase_nx;
        end
    end

    // Beats: completed blink periods spent in ALARM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat <= '0;
        end else if (state != ALARM) begin
            beat <= '0;
        end else if (!phase && phase_nx && beat != BEAT_MAX) begin
            beat <= beat + AW'(1);
        end
    end

    // Tone runs only through lit halves that stay in ALARM; buzzer is
    // forced low on the same edge the alarm ends or the display dims.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tone_cnt <= '0;
            buzzer_q <= 1'b0;
        end else if (state == ALARM && state_nx == ALARM &&
                     phase && phase_nx) begin
            if (tone_cnt == TONE_TC) begin
                tone_cnt <= '0;
                buzzer_q <= ~buzzer_q;
            end else begin
                tone_cnt <= tone_cnt + TW'(1);
            end
        end else begin
            tone_cnt <= '0;
            buzzer_q <= 1'b0;
        end
    end

    // Display content
    always_comb begin
        digit = 4'h0;
        unique case (idx)
            2'd0: digit = sec_h[3:0];
            2'd1: digit = sec_h[7:4];
            2'd2: digit = min_h[3:0];
            2'd3: digit = min_h[7:4];
        endcase
        if (state == SILENCED) begin
            digit = 4'h0;
        end

        seg_int = {1'b0, bcd_to_seg(digit)};

        // Blank the segments only; the digit slot stays lit in time.
        if (idx == 2'd3 && bus.blank_en && min_h[7:4] == 4'h0 &&
            state != SILENCED) begin
            seg_int[6:0] = 7'h00;
        end

        if (idx == 2'd2) begin
            seg_int[7] = (!mode_s || state != IDLE) ? 1'b1 : phase;
        end

        dig_int = 4'b0001 << idx;
        if (state == ALARM && !phase) begin
            dig_int = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q <= SEG_OFF;
            dig_q <= DIG_OFF;
        end else begin
            seg_q <= seg_int ^ SEG_OFF;
            dig_q <= dig_int ^ DIG_OFF;
        end
    end

    assign bus.seg    = seg_q;
    assign bus.dig    = dig_q;
    assign bus.buzzer = buzzer_q;

endmodule

// File: tb/tb_m_timer_display.sv
// Scoreboard bench for m_timer_display: stimulus queues expectations,
// a negedge monitor pops and compares them against the display pins.
module tb_m_timer_display;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    m_timer_display_if bus ();

    m_timer_display #(
        .SCAN_DIV      (4),
        .BLINK_DIV     (16),
        .TONE_DIV      (2),
        .ALARM_BEATS   (3),
        .SEG_ACTIVE_LOW(0),
        .DIG_ACTIVE_LOW(0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // slot=1: wait until dig shows the slot, then compare seg.
    // slot=0: compare the enabled fields at the next negedge.
    typedef struct packed {
        logic       slot;
        logic       cs;
        logic       cd;
        logic       cb;
        logic [7:0] seg;
        logic [3:0] dig;
        logic       buz;
    } exp_t;

    exp_t  q[$];
    string qn[$];
    int    compared   = 0;
    int    mismatched = 0;

    function automatic void cmp(input string nm, input string f,
                                input logic [7:0] got,
                                input logic [7:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s %s: got %h want %h", nm, f, got, want);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_now(input string nm,
                           input logic cs, input logic [7:0] s,
                           input logic cd, input logic [3:0] d,
                           input logic cb, input logic b);
        exp_t e;
        e.slot = 1'b0;
        e.cs   = cs;
        e.cd   = cd;
        e.cb   = cb;
        e.seg  = s;
        e.dig  = d;
        e.buz  = b;
        q.push_back(e);
        qn.push_back(nm);
    endtask

    task automatic exp_buz(input string nm, input logic b);
        exp_now(nm, 1'b0, 8'h00, 1'b0, 4'h0, 1'b1, b);
    endtask

    task automatic exp_slot(input string nm, input logic [3:0] d,
                            input logic [7:0] s);
        exp_t e;
        e.slot = 1'b1;
        e.cs   = 1'b1;
        e.cd   = 1'b0;
        e.cb   = 1'b0;
        e.seg  = s;
        e.dig  = d;
        e.buz  = 1'b0;
        q.push_back(e);
        qn.push_back(nm);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d checks left", q.size());
            q.delete();
            qn.delete();
        end
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        int    waitc;
        waitc = 0;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e  = q[0];
                nm = qn[0];
                if (!e.slot) begin
                    void'(q.pop_front());
                    void'(qn.pop_front());
                    if (e.cs) cmp(nm, "seg", bus.seg, e.seg);
                    if (e.cd) cmp(nm, "dig", {4'h0, bus.dig},
                                  {4'h0, e.dig});
                    if (e.cb) cmp(nm, "buzzer", {7'h0, bus.buzzer},
                                  {7'h0, e.buz});
                end else if (bus.dig === e.dig) begin
                    void'(q.pop_front());
                    void'(qn.pop_front());
                    waitc = 0;
                    cmp(nm, "seg", bus.seg, e.seg);
                end else begin
                    waitc++;
                    if (waitc > 40) begin
                        compared++;
                        mismatched++;
                        $display("FAIL %s dig: slot %b never shown, got %b",
                                 nm, e.dig, bus.dig);
                        void'(q.pop_front());
                        void'(qn.pop_front());
                        waitc = 0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n        = 1'b0;
        bus.min      = 8'h12;
        bus.sec      = 8'h34;
        bus.mode     = 1'b1;
        bus.time_end = 1'b1;
        bus.ack_btn  = 1'b0;
        bus.blank_en = 1'b0;

        // 1. reset and scan stepping
        tick(3);
        exp_now("reset", 1'b1, 8'h00, 1'b1, 4'h0, 1'b1, 1'b0);
        rst_n = 1'b1;
        tick(1);
        exp_now("scan_e1", 1'b0, 8'h00, 1'b1, 4'b0001, 1'b0, 1'b0);
        tick(3);
        exp_now("scan_e4", 1'b0, 8'h00, 1'b1, 4'b0001, 1'b0, 1'b0);
        tick(1);
        exp_now("scan_e5", 1'b0, 8'h00, 1'b1, 4'b0010, 1'b0, 1'b0);
        tick(4);
        exp_now("scan_e9", 1'b0, 8'h00, 1'b1, 4'b0100, 1'b0, 1'b0);
        tick(4);
        exp_now("scan_e13", 1'b0, 8'h00, 1'b1, 4'b1000, 1'b0, 1'b0);
        tick(4);
        exp_now("scan_e17", 1'b0, 8'h00, 1'b1, 4'b0001, 1'b1, 1'b0);
        tick(1);

        // 2. decode, set mode, colon steady
        bus.mode     = 1'b0;
        bus.time_end = 1'b0;
        tick(20);
        exp_slot("dec_s0", 4'b0001, 8'h66);
        exp_slot("dec_s1", 4'b0010, 8'h4F);
        exp_slot("dec_s2", 4'b0100, 8'hDB);
        exp_slot("dec_s3", 4'b1000, 8'h06);
        drain();
        bus.sec = 8'h3A;
        tick(20);
        exp_slot("dash", 4'b0001, 8'h40);
        drain();
        bus.sec = 8'h34;

        // 3. leading-zero blanking
        bus.min      = 8'h05;
        bus.blank_en = 1'b1;
        tick(20);
        exp_slot("blank_s2", 4'b0100, 8'hED);
        exp_slot("blank_s3", 4'b1000, 8'h00);
        drain();
        bus.blank_en = 1'b0;
        tick(20);
        exp_slot("noblank_s3", 4'b1000, 8'h3F);
        drain();

        // 4. alarm: flash, tone, auto-silence after 3 beats
        bus.min  = 8'h00;
        bus.sec  = 8'h00;
        bus.mode = 1'b1;
        tick(20);
        bus.time_end = 1'b1;
        tick(4);
        exp_buz("alm_a4", 1'b0);
        tick(1);
        exp_buz("alm_a5", 1'b1);
        tick(1);
        exp_buz("alm_a6", 1'b1);
        tick(1);
        exp_buz("alm_a7", 1'b0);
        tick(10);
        exp_buz("alm_a17", 1'b1);
        tick(2);
        exp_buz("alm_a19", 1'b0);
        tick(6);
        exp_now("flash_a25", 1'b0, 8'h00, 1'b1, 4'h0, 1'b1, 1'b0);
        tick(12);
        exp_buz("alm_a37", 1'b1);
        tick(1);
        exp_buz("alm_a38", 1'b1);
        tick(82);
        exp_buz("sil_a120", 1'b0);
        tick(1);
        exp_slot("sil_s2", 4'b0100, 8'hBF);
        exp_slot("sil_s0", 4'b0001, 8'h3F);
        drain();
        tick(30);
        exp_buz("sil_late", 1'b0);
        tick(1);
        exp_slot("sil_s1", 4'b0010, 8'h3F);
        drain();

        // 5. clear, re-arm, acknowledge, clear-beats-ack
        bus.time_end = 1'b0;
        tick(8);
        bus.time_end = 1'b1;
        tick(5);
        exp_buz("rearm_a5", 1'b1);
        tick(3);
        bus.ack_btn = 1'b1;
        tick(2);
        exp_buz("ack_a10", 1'b1);
        tick(1);
        exp_buz("ack_a11", 1'b0);
        tick(2);
        exp_buz("ack_a13", 1'b0);
        tick(20);
        exp_buz("ack_a33", 1'b0);
        tick(1);
        bus.ack_btn  = 1'b0;
        bus.time_end = 1'b0;
        tick(8);
        bus.time_end = 1'b1;
        tick(5);
        exp_buz("rearm2_a5", 1'b1);
        tick(1);
        bus.time_end = 1'b0;
        bus.ack_btn  = 1'b1;
        tick(6);
        exp_buz("clr_ack", 1'b0);
        tick(1);
        bus.ack_btn = 1'b0;
        tick(4);
        bus.time_end = 1'b1;
        tick(5);
        exp_buz("rearm3_a5", 1'b1);

        // 6. reset mid-alarm, no re-alarm on a held time_end
        rst_n = 1'b0;
        tick(1);
        exp_now("rst_alarm", 1'b1, 8'h00, 1'b1, 4'h0, 1'b1, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        exp_buz("post_r5", 1'b0);
        tick(1);
        exp_buz("post_r6", 1'b0);
        tick(3);
        exp_buz("post_r9", 1'b0);
        tick(10);
        exp_buz("post_r19", 1'b0);
        tick(6);
        exp_now("post_r25", 1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0);
        exp_slot("post_s0", 4'b0001, 8'h3F);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
